// File: rtl/multi_lane_datapath_reset_pkg.sv
`default_nettype none
// ============================================================================
// Module   : datapath_reset_pkg
// Brief    : Shared lane state encoding and counter width helper for the
//            multi-lane GT datapath reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package datapath_reset_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    RESET  = 2'd1,
    LOCKED = 2'd2,
    FAILED = 2'd3
  } lane_state_t;

  localparam int MIN_CNT_WIDTH = 1;

  // Width for a counter whose terminal value is limit-1; never below 1 bit.
  function automatic int cnt_width(input int limit);
    return (limit <= 2) ? MIN_CNT_WIDTH : $clog2(limit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_lane_datapath_reset_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_lane_datapath_reset_if
// Brief    : Per-lane status/control bundle between the GT wrapper side and
//            the datapath reset sequencer. reset_count exists only when
//            DATAPATH_RESET_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_lane_datapath_reset_if #(
  parameter int NUM_LANES  = 4,
  parameter int STAT_WIDTH = 16
);

  logic [NUM_LANES-1:0] lane_en;
  logic [NUM_LANES-1:0] channel_good;
  logic [NUM_LANES-1:0] clear_fail;
  logic [NUM_LANES-1:0] rst_out;
  logic [NUM_LANES-1:0] locked;
  logic [NUM_LANES-1:0] fail;
  logic                 all_locked;
  logic                 any_fail;
`ifdef DATAPATH_RESET_STATS_EN
  logic [NUM_LANES*STAT_WIDTH-1:0] reset_count;

  modport master (
    output lane_en, channel_good, clear_fail,
    input  rst_out, locked, fail, all_locked, any_fail, reset_count
  );

  modport slave (
    input  lane_en, channel_good, clear_fail,
    output rst_out, locked, fail, all_locked, any_fail, reset_count
  );
`else
  modport master (
    output lane_en, channel_good, clear_fail,
    input  rst_out, locked, fail, all_locked, any_fail
  );

  modport slave (
    input  lane_en, channel_good, clear_fail,
    output rst_out, locked, fail, all_locked, any_fail
  );
`endif

endinterface
`default_nettype wire

// File: rtl/multi_lane_datapath_reset_lane.sv
`default_nettype none
// ============================================================================
// Module   : datapath_reset_lane
// Brief    : One lane's lock search / reset pulse / retry FSM. With
//            DATAPATH_RESET_STATS_EN a saturating reset event counter is added.
// Revision : 1.0 - initial release
// ============================================================================
module datapath_reset_lane
  import datapath_reset_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32768,
  parameter int PULSE_CYCLES   = 4,
  parameter int STABLE_CYCLES  = 64,
  parameter int MAX_RETRIES    = 8
`ifdef DATAPATH_RESET_STATS_EN
  , parameter int STAT_WIDTH   = 16
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic good,
  input  logic clear_fail,
  output logic rst_out,
  output logic locked,
  output logic fail,
  output logic next_locked,
  output logic next_fail
`ifdef DATAPATH_RESET_STATS_EN
  , output logic [STAT_WIDTH-1:0] reset_count
`endif
);

  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam int SW = cnt_width(STABLE_CYCLES);
  localparam int PW = cnt_width(PULSE_CYCLES);
  localparam int RW = cnt_width(MAX_RETRIES + 1);

  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LAST  = PW'(PULSE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

  lane_state_t   state, next_state;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic [SW-1:0] stable_cnt, stable_nxt;
  logic [PW-1:0] pulse_cnt, pulse_nxt;
  logic [RW-1:0] retry_cnt, retry_nxt;
  logic          reset_entry;

  always_comb begin
    next_state  = state;
    tmo_nxt     = tmo_cnt;
    stable_nxt  = stable_cnt;
    pulse_nxt   = pulse_cnt;
    retry_nxt   = retry_cnt;
    reset_entry = 1'b0;
    if (!en) begin
      next_state = SEARCH;
      tmo_nxt    = '0;
      stable_nxt = '0;
      pulse_nxt  = '0;
      retry_nxt  = '0;
    end else begin
      unique case (state)
        SEARCH: begin
          if (good) begin
            tmo_nxt = '0;
            if (stable_cnt == STABLE_LAST) begin
              next_state = LOCKED;
              stable_nxt = '0;
              retry_nxt  = '0;
            end else begin
              stable_nxt = stable_cnt + SW'(1);
            end
          end else begin
            stable_nxt = '0;
            if (tmo_cnt == TMO_LAST) begin
              next_state  = RESET;
              tmo_nxt     = '0;
              pulse_nxt   = '0;
              reset_entry = 1'b1;
              if (retry_cnt != RETRY_MAX) retry_nxt = retry_cnt + RW'(1);
            end else begin
              tmo_nxt = tmo_cnt + TW'(1);
            end
          end
        end
        RESET: begin
          if (pulse_cnt == PULSE_LAST) begin
            pulse_nxt  = '0;
            tmo_nxt    = '0;
            stable_nxt = '0;
            next_state = (retry_cnt == RETRY_MAX) ? FAILED : SEARCH;
          end else begin
            pulse_nxt = pulse_cnt + PW'(1);
          end
        end
        LOCKED: begin
          if (!good) begin
            next_state = SEARCH;
            tmo_nxt    = '0;
            stable_nxt = '0;
            retry_nxt  = '0;
          end
        end
        FAILED: begin
          if (clear_fail) begin
            next_state = SEARCH;
            tmo_nxt    = '0;
            stable_nxt = '0;
            retry_nxt  = '0;
          end
        end
        default: next_state = SEARCH;
      endcase
    end
  end

  assign next_locked = (next_state == LOCKED);
  assign next_fail   = (next_state == FAILED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEARCH;
      tmo_cnt    <= '0;
      stable_cnt <= '0;
      pulse_cnt  <= '0;
      retry_cnt  <= '0;
      rst_out    <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= next_state;
      tmo_cnt    <= tmo_nxt;
      stable_cnt <= stable_nxt;
      pulse_cnt  <= pulse_nxt;
      retry_cnt  <= retry_nxt;
      rst_out    <= (next_state == RESET);
      locked     <= next_locked;
      fail       <= next_fail;
    end
  end

`ifdef DATAPATH_RESET_STATS_EN
  // Survives lane_en and clear_fail so escalation logic can see the history.
  always_ff @(posedge clk) begin
    if (rst) begin
      reset_count <= '0;
    end else if (reset_entry && (reset_count != {STAT_WIDTH{1'b1}})) begin
      reset_count <= reset_count + STAT_WIDTH'(1);
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/multi_lane_datapath_reset.sv
`default_nettype none
// ============================================================================
// Module   : multi_lane_datapath_reset
// Brief    : NUM_LANES independent datapath reset sequencers plus registered
//            all_locked/any_fail summaries. Optional: DATAPATH_RESET_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multi_lane_datapath_reset
  import datapath_reset_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int TIMEOUT_CYCLES = 32768,
  parameter int PULSE_CYCLES   = 4,
  parameter int STABLE_CYCLES  = 64,
  parameter int MAX_RETRIES    = 8,
  parameter int STAT_WIDTH     = 16
) (
  input logic                        clk,
  input logic                        rst,
  multi_lane_datapath_reset_if.slave bus
);

  logic [NUM_LANES-1:0] rst_out_vec;
  logic [NUM_LANES-1:0] locked_vec;
  logic [NUM_LANES-1:0] fail_vec;
  logic [NUM_LANES-1:0] next_locked_vec;
  logic [NUM_LANES-1:0] next_fail_vec;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    datapath_reset_lane #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .PULSE_CYCLES   (PULSE_CYCLES),
      .STABLE_CYCLES  (STABLE_CYCLES),
      .MAX_RETRIES    (MAX_RETRIES)
`ifdef DATAPATH_RESET_STATS_EN
      , .STAT_WIDTH   (STAT_WIDTH)
`endif
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .en          (bus.lane_en[i]),
      .good        (bus.channel_good[i]),
      .clear_fail  (bus.clear_fail[i]),
      .rst_out     (rst_out_vec[i]),
      .locked      (locked_vec[i]),
      .fail        (fail_vec[i]),
      .next_locked (next_locked_vec[i]),
      .next_fail   (next_fail_vec[i])
`ifdef DATAPATH_RESET_STATS_EN
      , .reset_count (bus.reset_count[i*STAT_WIDTH +: STAT_WIDTH])
`endif
    );
  end

  assign bus.rst_out = rst_out_vec;
  assign bus.locked  = locked_vec;
  assign bus.fail    = fail_vec;

  // Built from next-state values so the summaries move on the same edge as the lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.all_locked <= 1'b0;
      bus.any_fail   <= 1'b0;
    end else begin
      bus.all_locked <= (|bus.lane_en) && (&(next_locked_vec | ~bus.lane_en));
      bus.any_fail   <= |next_fail_vec;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_lane_datapath_reset.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_lane_datapath_reset
// Brief    : Directed and random checks of the datapath reset sequencer
//            against a run-length reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_lane_datapath_reset;

  localparam int N  = 2;
  localparam int T  = 8;
  localparam int P  = 2;
  localparam int S  = 4;
  localparam int R  = 3;
  localparam int SW = 2;

  localparam int M_SEARCH = 0;
  localparam int M_PULSE  = 1;
  localparam int M_LOCK   = 2;
  localparam int M_FAIL   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_lane_datapath_reset_if #(.NUM_LANES(N), .STAT_WIDTH(SW)) bus ();

  multi_lane_datapath_reset #(
    .NUM_LANES      (N),
    .TIMEOUT_CYCLES (T),
    .PULSE_CYCLES   (P),
    .STABLE_CYCLES  (S),
    .MAX_RETRIES    (R),
    .STAT_WIDTH     (SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference: each lane tracks run lengths of good/bad cycles, pulse cycles left and tries.
  int m_mode [N];
  int m_good_run [N];
  int m_bad_run [N];
  int m_left [N];
  int m_tries [N];
  int m_rc [N];
  logic [N-1:0] m_en;

  function automatic void model_step(input bit r, input logic [N-1:0] en,
                                     input logic [N-1:0] good, input logic [N-1:0] clr);
    m_en = r ? '0 : en;
    for (int i = 0; i < N; i++) begin
      if (r) begin
        m_mode[i] = M_SEARCH; m_good_run[i] = 0; m_bad_run[i] = 0;
        m_left[i] = 0; m_tries[i] = 0; m_rc[i] = 0;
      end else if (!en[i]) begin
        m_mode[i] = M_SEARCH; m_good_run[i] = 0; m_bad_run[i] = 0;
        m_left[i] = 0; m_tries[i] = 0;
      end else if (m_mode[i] == M_SEARCH) begin
        if (good[i]) begin
          m_bad_run[i] = 0;
          m_good_run[i]++;
          if (m_good_run[i] == S) begin
            m_mode[i] = M_LOCK; m_good_run[i] = 0; m_tries[i] = 0;
          end
        end else begin
          m_good_run[i] = 0;
          m_bad_run[i]++;
          if (m_bad_run[i] == T) begin
            m_mode[i] = M_PULSE; m_bad_run[i] = 0; m_left[i] = P;
            m_tries[i] = (m_tries[i] < R) ? m_tries[i] + 1 : R;
            m_rc[i] = (m_rc[i] < (1 << SW) - 1) ? m_rc[i] + 1 : m_rc[i];
          end
        end
      end else if (m_mode[i] == M_PULSE) begin
        m_left[i]--;
        if (m_left[i] == 0) m_mode[i] = (m_tries[i] == R) ? M_FAIL : M_SEARCH;
      end else if (m_mode[i] == M_LOCK) begin
        if (!good[i]) begin m_mode[i] = M_SEARCH; m_tries[i] = 0; end
      end else begin
        if (clr[i]) begin m_mode[i] = M_SEARCH; m_tries[i] = 0; end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] er, el, ef;
    logic eal;
    for (int i = 0; i < N; i++) begin
      er[i] = (m_mode[i] == M_PULSE);
      el[i] = (m_mode[i] == M_LOCK);
      ef[i] = (m_mode[i] == M_FAIL);
    end
    eal = (m_en != '0) && ((el | ~m_en) == {N{1'b1}});
    check("rst_out", 64'(bus.rst_out), 64'(er));
    check("locked", 64'(bus.locked), 64'(el));
    check("fail", 64'(bus.fail), 64'(ef));
    check("all_locked", 64'(bus.all_locked), 64'(eal));
    check("any_fail", 64'(bus.any_fail), 64'(|ef));
`ifdef DATAPATH_RESET_STATS_EN
    for (int i = 0; i < N; i++)
      check("reset_count", 64'(bus.reset_count[i*SW +: SW]), 64'(m_rc[i]));
`endif
  endtask

  task automatic step(input bit r, input logic [N-1:0] en,
                      input logic [N-1:0] good, input logic [N-1:0] clr);
    rst = r;
    bus.lane_en = en;
    bus.channel_good = good;
    bus.clear_fail = clr;
    @(posedge clk);
    model_step(r, en, good, clr);
    #1;
    compare_all();
  endtask

  initial begin
    logic [63:0] mask, exp_mask;
    logic [7:0] pat;
    int first0, first1, pulses;
    logic prev;

    // Reset state
    step(1'b1, 2'b11, 2'b00, 2'b00);
    step(1'b1, 2'b11, 2'b00, 2'b00);
    check("reset_outputs", 64'({bus.rst_out, bus.locked, bus.fail, bus.all_locked, bus.any_fail}), 64'd0);

    // Timeout pulses at cycles 8-9, 18-19, 28-29, then FAILED from cycle 30
    mask = '0;
    for (int k = 1; k <= 35; k++) begin
      step(1'b0, 2'b11, 2'b00, 2'b00);
      if (bus.rst_out[0]) mask[k] = 1'b1;
      if (k == 29) check("fail_before_30", 64'(bus.fail[0]), 64'd0);
      if (k == 30) check("fail_at_30", 64'(bus.fail[0]), 64'd1);
    end
    exp_mask = '0;
    exp_mask[8] = 1'b1;  exp_mask[9] = 1'b1;
    exp_mask[18] = 1'b1; exp_mask[19] = 1'b1;
    exp_mask[28] = 1'b1; exp_mask[29] = 1'b1;
    check("pulse_cycles", mask, exp_mask);
    check("any_fail_set", 64'(bus.any_fail), 64'd1);

    // Lock needs 4 consecutive good cycles
    step(1'b1, 2'b00, 2'b00, 2'b00);
    pat = 8'b1111_0111;
    for (int j = 0; j < 8; j++) begin
      step(1'b0, 2'b01, {1'b0, pat[j]}, 2'b00);
      if (j == 6) check("lock_early", 64'(bus.locked[0]), 64'd0);
      if (j == 7) check("lock_4th_good", 64'(bus.locked[0]), 64'd1);
    end

    // Drop from LOCKED, pulse 8 cycles after the drop, then 3 fresh retries
    step(1'b0, 2'b01, 2'b01, 2'b00);
    step(1'b0, 2'b01, 2'b00, 2'b00);
    check("unlock_next_edge", 64'(bus.locked[0]), 64'd0);
    first0 = -1;
    for (int k = 1; k <= 20 && first0 < 0; k++) begin
      step(1'b0, 2'b01, 2'b00, 2'b00);
      if (bus.rst_out[0]) first0 = k;
    end
    check("pulse_after_drop", 64'(first0), 64'd8);
    pulses = 1;
    prev = 1'b1;
    for (int k = 0; k < 60 && !bus.fail[0]; k++) begin
      step(1'b0, 2'b01, 2'b00, 2'b00);
      if (bus.rst_out[0] && !prev) pulses++;
      prev = bus.rst_out[0];
    end
    check("retries_restart", 64'(pulses), 64'd3);
    check("failed_after_retries", 64'(bus.fail[0]), 64'd1);

    // clear_fail on FAILED lane0 and on SEARCH lane1
    for (int k = 0; k < 3; k++) step(1'b0, 2'b11, 2'b00, 2'b00);
    step(1'b0, 2'b11, 2'b00, 2'b11);
    check("clear_fail_drop", 64'(bus.fail[0]), 64'd0);
    first0 = -1;
    first1 = -1;
    for (int k = 1; k <= 20 && (first0 < 0 || first1 < 0); k++) begin
      step(1'b0, 2'b11, 2'b00, 2'b00);
      if (bus.rst_out[0] && first0 < 0) first0 = k;
      if (bus.rst_out[1] && first1 < 0) first1 = k;
    end
    check("pulse_after_clear", 64'(first0), 64'd8);
    check("clear_ignored_search", 64'(first1), 64'd4);

    // rst during the first pulse cycle, then lane1 disabled while lane0 locks
    step(1'b1, 2'b01, 2'b00, 2'b00);
    first0 = -1;
    for (int k = 1; k <= 20 && first0 < 0; k++) begin
      step(1'b0, 2'b01, 2'b00, 2'b00);
      if (bus.rst_out[0]) first0 = k;
    end
    check("pulse_before_rst", 64'(first0), 64'd8);
    step(1'b1, 2'b01, 2'b00, 2'b00);
    check("rst_mid_pulse", 64'(bus.rst_out[0]), 64'd0);
    for (int k = 0; k < 4; k++) step(1'b0, 2'b01, 2'b01, 2'b00);
    check("all_locked_lane0_only", 64'(bus.all_locked), 64'd1);
    check("lane1_silent", 64'(bus.rst_out[1]), 64'd0);

`ifdef DATAPATH_RESET_STATS_EN
    step(1'b1, 2'b01, 2'b00, 2'b00);
    for (int k = 0; k < 40 && !bus.fail[0]; k++) step(1'b0, 2'b01, 2'b00, 2'b00);
    step(1'b0, 2'b01, 2'b00, 2'b01);
    for (int k = 0; k < 20; k++) step(1'b0, 2'b01, 2'b00, 2'b00);
    check("stats_saturated", 64'(bus.reset_count[SW-1:0]), 64'd3);
    for (int k = 0; k < 20 && !bus.fail[0]; k++) step(1'b0, 2'b01, 2'b00, 2'b00);
    step(1'b0, 2'b01, 2'b00, 2'b01);
    check("stats_kept_on_clear", 64'(bus.reset_count[SW-1:0]), 64'd3);
    step(1'b1, 2'b01, 2'b00, 2'b00);
    check("stats_cleared_by_rst", 64'(bus.reset_count[SW-1:0]), 64'd0);
`endif

    // Random traffic with slowly varying per-lane good probability
    begin
      logic [N-1:0] en, good, clr, bias;
      bias = '0;
      for (int k = 0; k < 1500; k++) begin
        if ($urandom_range(0, 24) == 0) bias = N'($urandom);
        for (int i = 0; i < N; i++) begin
          en[i]   = ($urandom_range(0, 39) != 0);
          good[i] = bias[i] ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 9) == 0);
          clr[i]  = ($urandom_range(0, 14) == 0);
        end
        step(($urandom_range(0, 199) == 0), en, good, clr);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
